// File: rtl/bytecode_pkg.sv
// Shared opcodes, FSM states and scratch-memory slots for the bytecode CPU.
// Imported by the sequencer and its decoder.
package bytecode_pkg;

   localparam logic [7:0] OP_ALU2   = 8'h02;
   localparam logic [7:0] OP_ALU1   = 8'h01;
   localparam logic [7:0] OP_STI    = 8'hC2;
   localparam logic [7:0] OP_MOV    = 8'hE2;
   localparam logic [7:0] OP_OUT    = 8'h81;
   localparam logic [7:0] OP_CALL   = 8'hAA;
   localparam logic [7:0] OP_CALLIF = 8'hDA;
   localparam logic [7:0] OP_RET    = 8'h55;
   localparam logic [7:0] OP_HALT   = 8'hFF;

   localparam int SCR_A   = 0;
   localparam int SCR_B   = 1;
   localparam int SCR_RES = 2;
   localparam int SCR_OP  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CAP,
      S_EXEC,
      S_HALT
   } seq_state_t;

   typedef enum logic [3:0] {
      C_NOP,
      C_ALU,
      C_STI,
      C_MOV,
      C_OUT,
      C_CALL,
      C_CALLIF,
      C_RET,
      C_HALT
   } ins_class_t;

endpackage

// File: rtl/bytecode_sequencer_if.sv
// Control, ROM, ALU and print signals of the bytecode sequencer.
// master is the sequencer side, slave the surrounding system.
interface bytecode_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              enable;
   logic [ADDR_W-1:0] imem_addr;
   logic [7:0]        imem_data;
   logic [7:0]        alu_op;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic [7:0]        alu_result;
   logic [7:0]        result;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, enable, imem_data, alu_result,
      output imem_addr, alu_op, alu_a, alu_b,
      output result, out_valid, out_data,
      output busy, done, err
   );

   modport slave (
      output start, enable, imem_data, alu_result,
      input  imem_addr, alu_op, alu_a, alu_b,
      input  result, out_valid, out_data,
      input  busy, done, err
   );
endinterface

// File: rtl/bytecode_decoder.sv
// Opcode decode: operand count, instruction class, illegal flag.
module bytecode_decoder
   import bytecode_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] n_ops,
   output ins_class_t cls,
   output logic       illegal
);

   always_comb begin
      n_ops   = 2'd0;
      cls     = C_NOP;
      illegal = 1'b0;
      unique case (1'b1)
         opcode == OP_ALU2:   begin n_ops = 2'd3; cls = C_ALU;    end
         opcode == OP_ALU1:   begin n_ops = 2'd2; cls = C_ALU;    end
         opcode == OP_STI:    begin n_ops = 2'd2; cls = C_STI;    end
         opcode == OP_MOV:    begin n_ops = 2'd2; cls = C_MOV;    end
         opcode == OP_OUT:    begin n_ops = 2'd1; cls = C_OUT;    end
         opcode == OP_CALL:   begin n_ops = 2'd1; cls = C_CALL;   end
         opcode == OP_CALLIF: begin n_ops = 2'd1; cls = C_CALLIF; end
         opcode == OP_RET:    cls = C_RET;
         opcode == OP_HALT:   cls = C_HALT;
         default:             illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/bytecode_sequencer.sv
// Fetch/decode/execute FSM of the bytecode CPU: byte fetch via ADDR/CAP,
// inline scratch memory, single-level call/return and print strobes.
module bytecode_sequencer
   import bytecode_pkg::*;
#(
   parameter int                ADDR_W     = 10,
   parameter int                DMEM_DEPTH = 16,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input logic                  clk,
   input logic                  rst,
   bytecode_sequencer_if.master bus
);

   localparam int                MW     = $clog2(DMEM_DEPTH);
   localparam logic [ADDR_W-1:0] PC_MAX = '1;

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, link_q, link_d, iaddr_q, iaddr_d;
   logic              link_vld_q, link_vld_d, flag_q, flag_d;
   logic [7:0]        opc_q, opc_d, op0_q, op0_d, op1_q, op1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [7:0]        mem_q [DMEM_DEPTH];
   logic [7:0]        mem_d [DMEM_DEPTH];
   logic [7:0]        aop_q, aop_d, aa_q, aa_d, ab_q, ab_d;
   logic [7:0]        res_q, res_d, odata_q, odata_d;
   logic              oval_q, oval_d, busy_q, busy_d;
   logic              done_q, done_d, err_q, err_d;

   logic [7:0] dec_in;
   logic [1:0] n_ops;
   ins_class_t cls;
   logic       illegal;

   // The opcode byte is decoded live in its CAP cycle, later from opc_q.
   assign dec_in = (state_q == S_CAP && cnt_q == 2'd0) ?
                   bus.imem_data : opc_q;

   bytecode_decoder u_dec (
      .opcode  (dec_in),
      .n_ops   (n_ops),
      .cls     (cls),
      .illegal (illegal)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      link_d     = link_q;
      link_vld_d = link_vld_q;
      flag_d     = flag_q;
      iaddr_d    = iaddr_q;
      opc_d      = opc_q;
      op0_d      = op0_q;
      op1_d      = op1_q;
      cnt_d      = cnt_q;
      mem_d      = mem_q;
      aop_d      = aop_q;
      aa_d       = aa_q;
      ab_d       = ab_q;
      res_d      = res_q;
      odata_d    = odata_q;
      oval_d     = 1'b0;
      err_d      = err_q;
      if (bus.enable) begin
         unique case (state_q)
            S_IDLE, S_HALT: if (bus.start) begin
               state_d = S_ADDR;
               pc_d    = START_ADDR;
               err_d   = 1'b0;
               cnt_d   = 2'd0;
            end
            S_ADDR: begin
               iaddr_d = pc_q;
               state_d = S_CAP;
            end
            S_CAP: begin
               if (pc_q == PC_MAX) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  pc_d  = pc_q + ADDR_W'(1);
                  cnt_d = cnt_q + 2'd1;
                  if (cnt_q == 2'd0) begin
                     opc_d = bus.imem_data;
                     if (illegal) err_d = 1'b1;
                     if (cls == C_HALT) state_d = S_HALT;
                     else if (n_ops == 2'd0) state_d = S_EXEC;
                     else state_d = S_ADDR;
                  end else begin
                     if (cnt_q == 2'd1) op0_d = bus.imem_data;
                     else op1_d = bus.imem_data;
                     if (cls == C_ALU) begin
                        unique case (cnt_q)
                           2'd1: begin
                              aop_d         = bus.imem_data;
                              mem_d[SCR_OP] = bus.imem_data;
                           end
                           2'd2: begin
                              aa_d         = bus.imem_data;
                              mem_d[SCR_A] = bus.imem_data;
                           end
                           default: begin
                              ab_d         = bus.imem_data;
                              mem_d[SCR_B] = bus.imem_data;
                           end
                        endcase
                     end
                     state_d = (cnt_q == n_ops) ? S_EXEC : S_ADDR;
                  end
               end
            end
            S_EXEC: begin
               state_d = S_ADDR;
               cnt_d   = 2'd0;
               unique case (cls)
                  C_ALU: begin
                     mem_d[SCR_RES] = bus.alu_result;
                     res_d          = bus.alu_result;
                     flag_d         = (bus.alu_result == 8'd1);
                  end
                  C_STI: begin
                     mem_d[op0_q[MW-1:0]] = op1_q;
                     res_d                = op1_q;
                  end
                  C_MOV: begin
                     mem_d[op0_q[MW-1:0]] = mem_q[op1_q[MW-1:0]];
                     res_d                = mem_q[op1_q[MW-1:0]];
                  end
                  C_OUT: begin
                     oval_d  = 1'b1;
                     odata_d = (op0_q == 8'd2) ? bus.alu_result :
                               mem_q[op0_q[MW-1:0]];
                  end
                  C_CALL, C_CALLIF: if (cls == C_CALL || flag_q) begin
                     link_d     = pc_q;
                     link_vld_d = 1'b1;
                     pc_d       = ADDR_W'(op0_q);
                  end
                  C_RET: if (link_vld_q) begin
                     pc_d       = link_q;
                     link_vld_d = 1'b0;
                  end
                  default: ;
               endcase
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
      done_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= START_ADDR;
         link_q     <= '0;
         link_vld_q <= 1'b0;
         flag_q     <= 1'b0;
         iaddr_q    <= '0;
         opc_q      <= '0;
         op0_q      <= '0;
         op1_q      <= '0;
         cnt_q      <= '0;
         mem_q      <= '{default: '0};
         aop_q      <= '0;
         aa_q       <= '0;
         ab_q       <= '0;
         res_q      <= '0;
         odata_q    <= '0;
         oval_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         link_q     <= link_d;
         link_vld_q <= link_vld_d;
         flag_q     <= flag_d;
         iaddr_q    <= iaddr_d;
         opc_q      <= opc_d;
         op0_q      <= op0_d;
         op1_q      <= op1_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
         aop_q      <= aop_d;
         aa_q       <= aa_d;
         ab_q       <= ab_d;
         res_q      <= res_d;
         odata_q    <= odata_d;
         oval_q     <= oval_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.imem_addr = iaddr_q;
   assign bus.alu_op    = aop_q;
   assign bus.alu_a     = aa_q;
   assign bus.alu_b     = ab_q;
   assign bus.result    = res_q;
   assign bus.out_valid = oval_q;
   assign bus.out_data  = odata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Directed bench for bytecode_sequencer: ROM programs, ALU stub,
// print-value scoreboard and cycle-count checks.
module tb_bytecode_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   int         checks = 0;
   int         failures = 0;
   int         n;
   logic [7:0] rom [1024];
   logic [7:0] prog [$];
   logic [7:0] exp_q [$];

   bytecode_sequencer_if #(.ADDR_W(10)) bus_if ();

   bytecode_sequencer #(
      .ADDR_W     (10),
      .DMEM_DEPTH (16),
      .START_ADDR (10'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   assign bus_if.imem_data = rom[bus_if.imem_addr];

   // ALU stub: op 0 add, op 1 subtract, anything else xor.
   always_comb begin
      bus_if.alu_result = bus_if.alu_a ^ bus_if.alu_b;
      if (bus_if.alu_op == 8'd0) bus_if.alu_result = bus_if.alu_a + bus_if.alu_b;
      if (bus_if.alu_op == 8'd1) bus_if.alu_result = bus_if.alu_a - bus_if.alu_b;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus_if.out_valid) begin
         if (exp_q.size() == 0)
            check("extra_out", 32'(bus_if.out_valid), 32'd0);
         else
            check("out_data", 32'(bus_if.out_data), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic load(input logic [7:0] fill);
      foreach (rom[i]) rom[i] = fill;
      foreach (prog[i]) rom[i] = prog[i];
   endtask

   task automatic run(input int budget, output int cyc);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      cyc = 0;
      while (!bus_if.done && cyc < budget) begin
         tick();
         cyc++;
      end
      check("done_seen", 32'(bus_if.done), 32'd1);
      check("out_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus_if.start = 1'b0;
      bus_if.enable = 1'b1;
      prog = '{8'hFF};
      load(8'hFF);
      tick();
      tick();
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_done", 32'(bus_if.done), 32'd0);
      check("rst_err", 32'(bus_if.err), 32'd0);
      check("rst_oval", 32'(bus_if.out_valid), 32'd0);
      check("rst_addr", 32'(bus_if.imem_addr), 32'd0);
      check("rst_result", 32'(bus_if.result), 32'd0);
      rst = 1'b0;
      tick();

      // ALU2 add then HALT
      prog = '{8'h02, 8'h00, 8'h05, 8'h03, 8'hFF};
      load(8'hFF);
      run(100, n);
      check("alu2_cycles", 32'(n), 32'd11);
      check("alu2_a", 32'(bus_if.alu_a), 32'd5);
      check("alu2_b", 32'(bus_if.alu_b), 32'd3);
      check("alu2_result", 32'(bus_if.result), 32'd8);
      check("alu2_err", 32'(bus_if.err), 32'd0);
      check("alu2_busy", 32'(bus_if.busy), 32'd0);

      // STI / MOV / OUT
      prog = '{8'hC2, 8'h08, 8'h2A, 8'hE2, 8'h09, 8'h08, 8'h81, 8'h09, 8'hFF};
      load(8'hFF);
      exp_q.push_back(8'h2A);
      run(100, n);
      check("mov_result", 32'(bus_if.result), 32'h2A);

      // CALL / OUT alu_result / RET, alu_result preset to 1
      prog = '{8'h02, 8'h00, 8'h00, 8'h01, 8'hFF};
      load(8'hFF);
      run(100, n);
      prog = '{8'hAA, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h81, 8'h02, 8'h55, 8'hFF};
      load(8'hFF);
      exp_q.push_back(8'h01);
      run(100, n);
      check("call_halt_addr", 32'(bus_if.imem_addr), 32'd2);
      check("call_err", 32'(bus_if.err), 32'd0);
      prog = '{8'h55};
      load(8'hFF);
      run(100, n);
      check("ret_nolink_addr", 32'(bus_if.imem_addr), 32'd1);

      // CALLIF not taken with flag 0, then taken with flag 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prog = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hDA, 8'h10, 8'hC2, 8'h04,
               8'h11, 8'h02, 8'h00, 8'h00, 8'h01, 8'hDA, 8'h10, 8'hFF,
               8'h81, 8'h04, 8'hFF};
      load(8'hFF);
      exp_q.push_back(8'h11);
      run(200, n);
      check("callif_halt_addr", 32'(bus_if.imem_addr), 32'h12);

      // illegal opcode sets err and execution continues
      prog = '{8'h37, 8'hC2, 8'h05, 8'h07, 8'hFF};
      load(8'hFF);
      run(100, n);
      check("ill_err", 32'(bus_if.err), 32'd1);
      check("ill_result", 32'(bus_if.result), 32'd7);

      // enable low 3 cycles during ALU2 operand fetch
      prog = '{8'h02, 8'h00, 8'h05, 8'h03, 8'hFF};
      load(8'hFF);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      check("start_clr_err", 32'(bus_if.err), 32'd0);
      n = 0;
      repeat (3) begin tick(); n++; end
      bus_if.enable = 1'b0;
      repeat (3) begin tick(); n++; end
      bus_if.enable = 1'b1;
      while (!bus_if.done && n < 100) begin tick(); n++; end
      check("stall_done", 32'(bus_if.done), 32'd1);
      check("stall_cycles", 32'(n), 32'd14);
      check("stall_result", 32'(bus_if.result), 32'd8);

      // reset in the middle of an OUT fetch, then a clean rerun
      prog = '{8'h81, 8'h02, 8'hFF};
      load(8'hFF);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
      check("mid_rst_addr", 32'(bus_if.imem_addr), 32'd0);
      check("mid_rst_alu_a", 32'(bus_if.alu_a), 32'd0);
      check("mid_rst_alu_b", 32'(bus_if.alu_b), 32'd0);
      check("mid_rst_result", 32'(bus_if.result), 32'd0);
      check("mid_rst_oval", 32'(bus_if.out_valid), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      exp_q.push_back(8'h00);
      run(100, n);
      check("rerun_err", 32'(bus_if.err), 32'd0);

      // run off the end of the ROM without HALT
      prog.delete();
      load(8'h55);
      run(4000, n);
      check("ovf_cycles", 32'(n), 32'd3071);
      check("ovf_err", 32'(bus_if.err), 32'd1);
      check("ovf_addr", 32'(bus_if.imem_addr), 32'd1023);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
